// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared state encoding and counter sizing for seq_divider
package seq_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    localparam int DEFAULT_WIDTH = 4;

    // Iteration counter must hold WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_divider_full_adder.sv
// rtl/seq_divider_full_adder.sv - single-bit full adder cell
module div_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule

// File: rtl/seq_divider_trial_subtract.sv
// rtl/seq_divider_trial_subtract.sv - (WIDTH+1)-bit trial subtract t - {0,divisor} via ripple adder
module div_trial_subtract #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   t_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             no_borrow_o
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        div_full_adder u_fa (
            .a_i  (t_i[i]),
            .b_i  (~divisor_i[i]),
            .ci_i (carry[i]),
            .s_o  (diff_o[i]),
            .co_o (carry[i+1])
        );
    end

    // The top divisor bit is a constant 0 (inverted to 1), so the top cell's
    // carry reduces to an OR; its sum bit is always 0 whenever no_borrow is set.
    assign no_borrow_o = t_i[WIDTH] | carry[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [2*WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0]   i_divisor,
    output logic               o_busy,
    output logic               o_done,
    output logic [WIDTH-1:0]   o_quotient,
    output logic [WIDTH-1:0]   o_remainder,
    output logic               o_overflow,
    output logic               o_div_by_zero
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] shf_q, shf_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             ovf_q, ovf_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] diff;
    logic             no_borrow;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] shf_next;
    logic             in_ovf;

    // Partial remainder stays below the divisor, so its W+1-th bit is always 0
    // and only the low WIDTH bits are stored.
    assign t = {rem_q, shf_q[WIDTH-1]};

    div_trial_subtract #(
        .WIDTH (WIDTH)
    ) u_sub (
        .t_i         (t),
        .divisor_i   (dvs_q),
        .diff_o      (diff),
        .no_borrow_o (no_borrow)
    );

    assign rem_next = no_borrow ? diff : t[WIDTH-1:0];
    assign shf_next = {shf_q[WIDTH-2:0], no_borrow};
    assign in_ovf   = (i_divisor == '0) || (i_dividend[2*WIDTH-1:WIDTH] >= i_divisor);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        shf_d   = shf_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    rem_d = i_dividend[2*WIDTH-1:WIDTH];
                    shf_d = i_dividend[WIDTH-1:0];
                    dvs_d = i_divisor;
                    ovf_d = 1'b0;
                    dbz_d = 1'b0;
                    if (in_ovf) begin
                        ovf_d   = 1'b1;
                        dbz_d   = (i_divisor == '0);
                        quot_d  = '1;
                        remo_d  = '0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                rem_d = rem_next;
                shf_d = shf_next;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    quot_d  = shf_next;
                    remo_d  = rem_next;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            shf_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            shf_q   <= shf_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign o_busy        = (state_q != ST_IDLE);
    assign o_done        = done_q;
    assign o_quotient    = quot_q;
    assign o_remainder   = remo_q;
    assign o_overflow    = ovf_q;
    assign o_div_by_zero = dbz_q;

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider; the inverse operation of the team's combinational array multiplier.
- Takes a 2*WIDTH-bit dividend (a multiplier product width) and a WIDTH-bit divisor.
- Produces a WIDTH-bit quotient and a WIDTH-bit remainder, one quotient bit per clock, under a start/done handshake.
- Sits beside the multiplier in the lab arithmetic datapath.

Parameters:
- WIDTH, 4, divisor/quotient/remainder width; dividend is 2*WIDTH; WIDTH >= 2.

Ports:
- i_clk  input  1  rising-edge clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  request; sampled only in IDLE.
- i_dividend  input  2*WIDTH  unsigned dividend, sampled with accepted i_start.
- i_divisor  input  WIDTH  unsigned divisor, sampled with accepted i_start.
- o_busy  output  1  high in CALC and DONE.
- o_done  output  1  one-cycle completion pulse.
- o_quotient  output  WIDTH  result quotient.
- o_remainder  output  WIDTH  result remainder.
- o_overflow  output  1  quotient does not fit in WIDTH bits (includes divide by zero).
- o_div_by_zero  output  1  divisor was 0.

Behaviour:
- One clock domain; reset is asynchronous and active-low. While i_rst_n=0: state=IDLE, counter=0, all outputs 0, internal registers 0.
- States:
  - IDLE: i_start=1 at edge E0 latches the operands.
  - From IDLE, overflow check at E0: if i_divisor == 0 or i_dividend[2W-1:W] >= i_divisor, go directly to DONE.
  - From IDLE, no overflow: go to CALC with partial remainder r(W+1 bits) = {0, dividend high half}, shift register = dividend low half, counter = WIDTH.
  - CALC: each edge, t = {r[W-1:0], shift MSB}, shift <<= 1.
    - If t >= {0, divisor}: r = t - divisor and shift LSB = 1.
    - Otherwise r = t and shift LSB = 0.
    - Counter decrements; the edge where the counter goes 1->0 moves to DONE.
  - DONE: lasts exactly one cycle, then IDLE.
- Timing, normal case: iterations at E1..EWIDTH.
  - At EWIDTH, o_quotient = final shift register and o_remainder = r[W-1:0] are registered together with o_done=1.
  - o_done drops at EWIDTH+1. Latency: result visible WIDTH cycles after the start edge.
- Overflow case: at E0, o_overflow=1, o_div_by_zero=(divisor==0), o_quotient=all ones, o_remainder=0, o_done=1. Latency 1 edge.
- Flags and results are held stable after DONE until the next accepted start. At the next accepted start, o_overflow and o_div_by_zero clear, except at E0 of another overflow request.
- Handshake:
  - i_start is ignored (operands not sampled) in CALC and DONE.
  - Earliest back-to-back accept is the edge after DONE→IDLE (EWIDTH+2).
  - Operands may change freely after the accept edge.
- Invariant in CALC: r < divisor before each shift, so t < 2*divisor fits in W+1 bits. The subtract is W+1-bit unsigned, and the borrow-out selects restore.
- Reset asserted mid-CALC: immediate return to IDLE, outputs 0, no o_done for the aborted operation.
- i_start held high continuously: a new operation is accepted every time the FSM re-enters IDLE.

Decomposition:
- Shared package/include: state encodings (IDLE, CALC, DONE) and the counter-width constant (clog2(WIDTH+1)).
- Sub-module div_trial_subtract: (W+1)-bit combinational trial subtractor, built from the team's full-adder cells with the divisor inverted and carry-in 1.
  - Outputs: difference and a no-borrow flag (1 = t >= divisor).
- FSM, counter and registers stay in seq_divider.

Test Plan:
- WIDTH=4, dividend=100, divisor=7 -> after 4 cycles: o_done pulse, quotient=14, remainder=2, overflow=0.
- dividend=225, divisor=15 -> quotient=15, remainder=0, overflow=0; then dividend=240, divisor=15 -> overflow=1, div_by_zero=0, quotient=4'hF, remainder=0, o_done 1 edge after start.
- dividend=50, divisor=0 -> o_overflow=1, o_div_by_zero=1, quotient=4'hF, remainder=0.
- Start 100/7, then pulse i_start with 9/3 during CALC -> pulse ignored, result 14 r 2; 9/3 issued after DONE -> quotient=3, remainder=0.
- Deassert i_rst_n at E2 of 100/7 -> outputs 0 immediately, no o_done; new 20/6 after release -> quotient=3, remainder=2.
- Exhaustive: all divisors 1..15, dividends with high half < divisor -> quotient*divisor+remainder == dividend and remainder < divisor; zero mismatches reported.
